// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the multiply/divide sequencer state type.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Operand magnitudes, 2*XLEN accumulator and one shift-add / restoring-divide
// step per cycle; sign fix and result selection on the final step.
module muldiv_datapath
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            fin_i,
  input  logic            spec_i,
  input  logic [XLEN-1:0] spec_val_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] result_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN-1:0]   diff, div_raw;
  logic              ge;
  logic [2*XLEN-1:0] mul_next, div_next, acc_step, mul_fix;
  logic [XLEN-1:0]   fixed;

  always_comb begin
    a_sgn = (funct3_i == F3_MULH) | (funct3_i == F3_MULHSU) |
            (funct3_i == F3_DIV)  | (funct3_i == F3_REM);
    b_sgn = (funct3_i == F3_MULH) | (funct3_i == F3_DIV) | (funct3_i == F3_REM);
    a_neg = a_sgn & op_a_i[XLEN-1];
    b_neg = b_sgn & op_b_i[XLEN-1];
    a_mag = a_neg ? ('0 - op_a_i) : op_a_i;
    b_mag = b_neg ? ('0 - op_b_i) : op_b_i;

    // Multiply: low half holds the shrinking multiplier, high half the partial sum.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: high half is the partial remainder, quotient bits shift into the low half.
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    ge       = (rem_sh >= {1'b0, b_q});
    diff     = rem_sh[XLEN-1:0] - b_q;
    div_next = {(ge ? diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};

    acc_step = f3_q[2] ? div_next : mul_next;

    // Multiply sign fix negates the full product; divide negates the chosen half.
    mul_fix = neg_q ? ('0 - acc_step) : acc_step;
    div_raw = f3_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    if (f3_q[2])
      fixed = neg_q ? ('0 - div_raw) : div_raw;
    else if (f3_q == F3_MUL)
      fixed = mul_fix[XLEN-1:0];
    else
      fixed = mul_fix[2*XLEN-1:XLEN];

    acc_d    = acc_q;
    b_d      = b_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, a_mag};
      b_d   = b_mag;
      f3_d  = funct3_i;
      neg_d = (funct3_i == F3_REM) ? a_neg : (a_neg ^ b_neg);
    end else if (step_i) begin
      acc_d = acc_step;
    end
    if (spec_i)
      result_d = spec_val_i;
    else if (fin_i)
      result_d = fixed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/muldiv_controller.sv
// RV32M iterative multiply/divide sequencer: IDLE -> CALC -> DONE FSM that
// stalls the pipeline and drives the datapath strobes.
module muldiv_controller
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept, b_zero, sgn_ovf, special;
  logic            load, step, fin, spec_ld;
  logic [XLEN-1:0] spec_val;

  always_comb begin
    accept  = (state_q == IDLE) & valid_i & ~flush_i;
    b_zero  = (op_b_i == '0);
    sgn_ovf = ((funct3_i == F3_DIV) | (funct3_i == F3_REM)) &
              (op_a_i == INT_MIN) & (op_b_i == '1);
    special = funct3_i[2] & (b_zero | sgn_ovf);
    if (b_zero)
      spec_val = funct3_i[1] ? op_a_i : '1;
    else
      spec_val = funct3_i[1] ? '0 : INT_MIN;

    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    spec_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (special) begin
            spec_ld = 1'b1;
            state_d = DONE;
          end else begin
            load    = 1'b1;
            cnt_d   = CW'(XLEN - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == '0) begin
            fin     = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == CALC);
  assign done_o  = (state_q == DONE);
  assign stall_o = busy_o | (ready_o & valid_i & ~flush_i);

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .fin_i     (fin),
    .spec_i    (spec_ld),
    .spec_val_i(spec_val),
    .funct3_i  (funct3_i),
    .op_a_i    (op_a_i),
    .op_b_i    (op_b_i),
    .result_o  (result_o)
  );

endmodule
